// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack handshake, byte-lane steering, load extension.
// Optional bus-error timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Datatype,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_Data2,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignExc,
    output logic        BusErr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_buserr;
    logic [1:0]  r_dtype;
    logic [1:0]  r_off;

    logic        w_access;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Lane select followed by sign/zero extension according to the access type.
    function automatic logic [31:0] f_extend(input logic [31:0] rd, input logic [1:0] dt,
                                             input logic [1:0] off);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? rd[31:16] : rd[15:0];
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (dt)
            2'b00:   f_extend = rd;
            2'b01:   f_extend = {{16{h[15]}}, h};
            2'b10:   f_extend = {{24{b[7]}}, b};
            default: f_extend = {24'd0, b};
        endcase
    endfunction

    assign w_access   = MEM_MemRead | MEM_MemWrite;
    assign w_misalign = ((MEM_Datatype == 2'b00) && (MEM_ALUResult[1:0] != 2'b00)) ||
                        ((MEM_Datatype == 2'b01) && MEM_ALUResult[0]);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = MEM_Data2;
        case (MEM_Datatype)
            2'b00: begin
                w_be    = 4'b1111;
                w_wdata = MEM_Data2;
            end
            2'b01: begin
                w_be    = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{MEM_Data2[15:0]}};
            end
            default: begin
                w_be    = 4'b0001 << MEM_ALUResult[1:0];
                w_wdata = {4{MEM_Data2[7:0]}};
            end
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_dtype    <= 2'd0;
            r_off      <= 2'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_misalign <= w_access & w_misalign;
                    if (w_access && !w_misalign) begin
                        r_addr  <= {MEM_ALUResult[31:2], 2'b00};
                        r_we    <= MEM_MemWrite;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_dtype <= MEM_Datatype;
                        r_off   <= MEM_ALUResult[1:0];
                        r_req   <= 1'b1;
                        r_state <= ACCESS;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // Ack wins over a timeout landing on the same edge.
                    if (dm_ack) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        if (!r_we)
                            r_rdata <= f_extend(dm_rdata, r_dtype, r_off);
                        r_state <= DONE;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_buserr <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Stall = !Clr && (((r_state == IDLE) && w_access && !w_misalign) ||
                            (r_state == ACCESS));

    assign dm_req      = r_req;
    assign dm_we       = r_we;
    assign dm_addr     = r_addr;
    assign dm_wdata    = r_wdata;
    assign dm_be       = r_be;
    assign ReadData    = r_rdata;
    assign MisalignExc = r_misalign;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign BusErr      = r_buserr;
`else
    assign BusErr      = 1'b0;
`endif

endmodule
